pipe_ctrl: RTL and testbench

//  Central pipeline sequencer for the 6-stage core (pc/if/id/ex/mem/wb). Merges per-stage stall

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_ctrl_stall_encoder.sv | 26 ++
 rtl/pipe_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: stall bus layout,
// per-requester stall masks and FSM state encodings.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    typedef logic [STALL_W-1:0] stall_bus_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Each mask holds the requesting stage and everything upstream of it
    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_IF   = 6'b000011;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_EX   = 6'b001111;
    localparam stall_bus_t STALL_MEM  = 6'b011111;
    localparam stall_bus_t STALL_ALL  = 6'b111111;
    localparam stall_bus_t STALL_PC   = 6'b000001;

    typedef enum logic [1:0] {
        PC_IDLE  = 2'd0,
        PC_WAIT  = 2'd1,
        PC_FLUSH = 2'd2,
        PC_DRAIN = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_encoder.sv
// Priority encoder turning per-stage stall requests into the stall bus.
// The most downstream requester wins so later stages keep draining.
module stall_encoder
    import pipe_ctrl_pkg::*;
(
    input  logic       stallreq_if,
    input  logic       stallreq_id,
    input  logic       stallreq_ex,
    input  logic       stallreq_mem,
    output logic [5:0] stall_mask
);

    always_comb begin
        stall_mask = STALL_NONE;
        if (stallreq_mem) begin
            stall_mask = STALL_MEM;
        end else if (stallreq_ex) begin
            stall_mask = STALL_EX;
        end else if (stallreq_id) begin
            stall_mask = STALL_ID;
        end else if (stallreq_if) begin
            stall_mask = STALL_IF;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: merges stall requests, sequences exception
// flushes behind outstanding bus traffic and counts stalled cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int EXC_PC_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_if,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                stallreq_mem,
    input  logic                except_valid,
    input  logic [EXC_PC_W-1:0] except_target,
    input  logic                ic_busy,
    input  logic                dc_busy,
    output logic [5:0]          stall,
    output logic                flush,
    output logic [EXC_PC_W-1:0] new_pc,
    output logic [CNT_W-1:0]    stall_cycles
);

    pc_state_e             state;
    pc_state_e             next_state;
    logic [EXC_PC_W-1:0]   target_q;
    logic [5:0]            req_mask;
    logic                  bus_busy;

    assign bus_busy = ic_busy | dc_busy;

    stall_encoder u_stall_encoder (
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .stall_mask   (req_mask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PC_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Only an exception accepted in IDLE captures a target; younger ones are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q <= '0;
        end else if (state == PC_IDLE && except_valid) begin
            target_q <= except_target;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            PC_IDLE: begin
                if (except_valid) begin
                    next_state = bus_busy ? PC_WAIT : PC_FLUSH;
                end
            end
            PC_WAIT: begin
                if (!bus_busy) begin
                    next_state = PC_FLUSH;
                end
            end
            PC_FLUSH: next_state = PC_DRAIN;
            PC_DRAIN: next_state = PC_IDLE;
            default:  next_state = PC_IDLE;
        endcase
    end

    always_comb begin
        stall  = STALL_NONE;
        flush  = 1'b0;
        new_pc = '0;
        case (state)
            PC_IDLE:  stall = req_mask;
            PC_WAIT:  stall = STALL_ALL;
            PC_FLUSH: begin
                flush  = 1'b1;
                new_pc = target_q;
            end
            PC_DRAIN: stall = STALL_PC;
            default:  stall = STALL_NONE;
        endcase
    end

    // Saturating count; a flush does not clear it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall != STALL_NONE && stall_cycles != {CNT_W{1'b1}}) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: stall encoding, exception
// flush sequencing with and without bus traffic, and async reset.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        except_valid;
    logic [31:0] except_target;
    logic        ic_busy;
    logic        dc_busy;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;

    int checkCount;
    int passCount;

    pipe_ctrl #(
        .CNT_W    (32),
        .EXC_PC_W (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .except_valid  (except_valid),
        .except_target (except_target),
        .ic_busy       (ic_busy),
        .dc_busy       (dc_busy),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Inputs change just after the active edge; checks happen on the falling edge
    task automatic applyStimulus(input logic s_if, input logic s_id, input logic s_ex,
                                 input logic s_mem, input logic ev, input logic [31:0] tgt,
                                 input logic icb, input logic dcb);
        @(posedge clk);
        #1;
        stallreq_if   = s_if;
        stallreq_id   = s_id;
        stallreq_ex   = s_ex;
        stallreq_mem  = s_mem;
        except_valid  = ev;
        except_target = tgt;
        ic_busy       = icb;
        dc_busy       = dcb;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    initial begin
        checkCount    = 0;
        passCount     = 0;
        rst           = 1'b0;
        stallreq_if   = 1'b0;
        stallreq_id   = 1'b0;
        stallreq_ex   = 1'b0;
        stallreq_mem  = 1'b0;
        except_valid  = 1'b0;
        except_target = 32'h0;
        ic_busy       = 1'b0;
        dc_busy       = 1'b0;

        #1 rst = 1'b1;
        #1;
        checkOutput("rst_stall", {26'h0, stall}, 32'h0);
        checkOutput("rst_flush", {31'h0, flush}, 32'h0);
        checkOutput("rst_new_pc", new_pc, 32'h0);
        checkOutput("rst_cnt", stall_cycles, 32'h0);
        rst = 1'b0;

        // Load-use hazard held for three cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 32'h0, 0, 0);
            @(negedge clk);
            checkOutput("id_stall", {26'h0, stall}, 32'h07);
            checkOutput("id_cnt", stall_cycles, 32'(i));
        end
        idleCycle();
        @(negedge clk);
        checkOutput("id_release", {26'h0, stall}, 32'h0);
        checkOutput("id_cnt_final", stall_cycles, 32'd3);

        // Mem outranks if; dropping mem falls back to if in the same cycle
        applyStimulus(1, 0, 0, 1, 0, 32'h0, 0, 0);
        @(negedge clk);
        checkOutput("mem_if_stall", {26'h0, stall}, 32'h1F);
        stallreq_mem = 1'b0;
        #1;
        checkOutput("if_only_stall", {26'h0, stall}, 32'h03);
        applyStimulus(0, 0, 1, 0, 0, 32'h0, 0, 0);
        @(negedge clk);
        checkOutput("ex_stall", {26'h0, stall}, 32'h0F);
        idleCycle();
        @(negedge clk);
        checkOutput("cnt_after_mix", stall_cycles, 32'd5);

        // Exception with idle buses: flush next cycle, then one drain cycle
        applyStimulus(0, 0, 0, 0, 1, 32'hBFC00380, 0, 0);
        @(negedge clk);
        checkOutput("exc_idle_flush", {31'h0, flush}, 32'h0);
        idleCycle();
        @(negedge clk);
        checkOutput("exc_flush", {31'h0, flush}, 32'h1);
        checkOutput("exc_new_pc", new_pc, 32'hBFC00380);
        checkOutput("exc_flush_stall", {26'h0, stall}, 32'h0);
        idleCycle();
        @(negedge clk);
        checkOutput("drain_stall", {26'h0, stall}, 32'h01);
        checkOutput("drain_flush", {31'h0, flush}, 32'h0);
        checkOutput("drain_new_pc", new_pc, 32'h0);
        idleCycle();
        @(negedge clk);
        checkOutput("post_drain_stall", {26'h0, stall}, 32'h0);
        checkOutput("post_drain_cnt", stall_cycles, 32'd6);

        // Exception behind a busy dcache, plus a younger exception that must be ignored
        applyStimulus(0, 0, 0, 0, 1, 32'h80000180, 0, 1);
        @(negedge clk);
        checkOutput("wait_entry_stall", {26'h0, stall}, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) applyStimulus(0, 0, 0, 1, 1, 32'h0, 0, 1);
            else        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, (i < 4));
            @(negedge clk);
            checkOutput("wait_stall", {26'h0, stall}, 32'h3F);
            checkOutput("wait_flush", {31'h0, flush}, 32'h0);
        end
        idleCycle();
        @(negedge clk);
        checkOutput("wait_exit_flush", {31'h0, flush}, 32'h1);
        checkOutput("wait_exit_new_pc", new_pc, 32'h80000180);
        idleCycle();
        @(negedge clk);
        checkOutput("wait_drain_stall", {26'h0, stall}, 32'h01);
        idleCycle();
        @(negedge clk);
        checkOutput("wait_done_stall", {26'h0, stall}, 32'h0);
        checkOutput("wait_done_cnt", stall_cycles, 32'd11);

        // Reset while waiting on the icache drops the pending redirect
        applyStimulus(0, 0, 0, 0, 1, 32'h12345678, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 0);
        @(negedge clk);
        checkOutput("pre_rst_stall", {26'h0, stall}, 32'h3F);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_stall", {26'h0, stall}, 32'h0);
        checkOutput("mid_rst_flush", {31'h0, flush}, 32'h0);
        checkOutput("mid_rst_cnt", stall_cycles, 32'h0);
        idleCycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_rst_flush", {31'h0, flush}, 32'h0);
            checkOutput("post_rst_stall", {26'h0, stall}, 32'h0);
            idleCycle();
        end
        @(negedge clk);
        checkOutput("post_rst_cnt", stall_cycles, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
